plot_line_interpolator: RTL and testbench
=========================================

Name: plot_line_interpolator

Overview:
- APB3 slave that accepts queued relative line moves (dx, dy) from the processor.
- Runs a Bresenham interpolator and issues paced, direction-qualified step requests for two axes.
- Feeds the downstream stepper pulse generator, which turns each request into a shaped STEP pulse.
- Lets firmware queue a whole pen stroke without polling per step.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of two, 2..16.
- DIR_SETUP, 4: PCLK cycles dir1/dir2 must be stable before the first step of a move.
- PERIOD_RST, 1000: reset value of the step-period register.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset, asynchronous, active-high
- PSEL  in  1  APB3 select
- PENABLE  in  1  APB3 access phase
- PWRITE  in  1  APB3 write
- PADDR  in  32  APB3 address; only [4:2] decoded
- PWDATA  in  32  APB3 write data
- PRDATA  out  32  APB3 read data
- PREADY  out  1  tied 1
- PSLVERR  out  1  error flag
- pulse_busy  in  1  downstream pulse generator still shaping the previous step
- step_req1  out  1  one-cycle step request, axis 1
- dir1  out  1  axis 1 direction; 1 = positive
- step_req2  out  1  one-cycle step request, axis 2
- dir2  out  1  axis 2 direction; 1 = positive
- done_irq  out  1  one-cycle pulse when the last queued move completes

Behaviour:
- Reset: PCLK single clock; PRESET asynchronous active-high. On reset all outputs are 0, FIFO is empty, PERIOD = PERIOD_RST, FSM is in IDLE.
- APB3 write commit: PSEL & PWRITE & PENABLE.
- Register map:
  - 0x00 CMD (W): dx = PWDATA[15:0], dy = PWDATA[31:16], both signed. Pushes one FIFO entry.
  - 0x04 PERIOD (R/W): [15:0] minimum PCLK cycles between steps; 0 is treated as 1.
  - 0x08 STATUS (R): {count[4:0] at [8:4], busy [2], full [1], empty [0]}.
  - 0x0C CTRL (W): bit0 = abort.
- CMD write when full: entry dropped; PSLVERR = 1 during that access phase only, else 0.
- Push and pop in the same cycle: legal; count unchanged.
- PRDATA is combinational from PADDR when PSEL & !PWRITE; 0 otherwise and for unmapped offsets.
- FSM states: IDLE, LOAD, SETUP, WAIT, STEP.
  - IDLE: if FIFO not empty -> LOAD.
  - LOAD: pop entry. Compute adx = |dx|, ady = |dy| (17-bit, so -32768 is safe). Latch dir1 = dx >= 0, dir2 = dy >= 0. Set major = max(adx, ady), minor = min, err = major >> 1 (18-bit signed), remaining = major.
    - major = 0 -> IDLE, no pulses.
    - otherwise -> SETUP.
  - SETUP: wait DIR_SETUP cycles -> WAIT with timer = PERIOD.
  - WAIT: timer decrements to 0. When timer == 0 and !pulse_busy -> STEP. pulse_busy stalls indefinitely.
  - STEP (1 cycle):
    - Major-axis step_req = 1.
    - err' = err - minor; if err' < 0, the minor-axis step_req = 1 in the same cycle and err = err' + major.
    - If adx == ady, both axes step every time.
    - remaining decrements. remaining reaches 0 -> IDLE, else WAIT with timer reloaded.
- Back-to-back moves: LOAD follows IDLE next cycle. dir1/dir2 change only in LOAD, and SETUP always precedes the first step.
- done_irq: pulses in the cycle STEP -> IDLE when the FIFO is empty.
- Abort: takes effect the cycle after commit and has priority over a same-cycle push. FIFO flushed, FSM -> IDLE, no step_req in any later cycle, dir held, no done_irq.
- PERIOD write mid-move: applies at the next timer reload.
- Reset mid-move: immediate return to reset state; the partial move is lost.

Optional Feature:
- PLOT_POS_COUNTER_EN defined:
  - Adds signed 32-bit position counters pos1/pos2, readable at 0x10/0x14.
  - Each counter is incremented/decremented per its step_req and dir.
  - Counters wrap mod 2^32, clear on reset, and are unaffected by abort.
- Undefined: 0x10/0x14 read 0 and no counter logic exists.

Decomposition:
- Package plot_pkg: register offsets, state enum, widths CMD_W = 16, ERR_W = 18, PERIOD_W = 16.
- Sub-module plot_cmd_fifo: synchronous FIFO with push/pop/flush, count/full/empty, same-cycle push+pop.
- Interpolator FSM and APB decode stay in the top module.

Test Plan:
- PERIOD = 10, CMD dx = 4, dy = 2 -> dir1 = dir2 = 1. Four step_req1 pulses 10 cycles apart. step_req2 coincides with the 2nd and 4th. One done_irq.
- CMD dx = -3, dy = 0 -> dir1 = 0 stable ≥ 4 cycles before the first step. Three step_req1 pulses, zero step_req2.
- Hold pulse_busy = 1 and write CMD ×5 -> writes 1–4 accepted, 5th PSLVERR = 1, STATUS.count = 4, full = 1. No steps until pulse_busy drops.
- CMD dx = 0, dy = 0 followed by dx = 2, dy = 2 -> no pulses for the first. Two cycles with both step_req1 and step_req2 for the second.
- dx = 100 mid-move, write CTRL = 1 -> no step_req after the abort cycle, STATUS = empty, no done_irq. Repeat with a PRESET pulse -> all outputs 0, PERIOD = 1000.
- With PLOT_POS_COUNTER_EN: dx = 5, then dx = -2 -> 0x10 reads 3. Without the macro: 0x10 reads 0.

Source files
------------

// File: rtl/plot_pkg.sv
// plot_pkg: shared offsets, widths, FSM states and helpers for the plot line interpolator
package plot_pkg;
  localparam int CMD_W = 16;
  localparam int ERR_W = 18;
  localparam int PERIOD_W = 16;
  localparam logic [2:0] OFF_CMD = 3'd0;
  localparam logic [2:0] OFF_PERIOD = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_CTRL = 3'd3;
  localparam logic [2:0] OFF_POS1 = 3'd4;
  localparam logic [2:0] OFF_POS2 = 3'd5;
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, WAIT, STEP} state_t;
  // one extra bit so |-32768| is representable
  function automatic logic [CMD_W:0] abs_ext(input logic [CMD_W-1:0] v);
    logic [CMD_W:0] s;
    s = {v[CMD_W-1], v};
    return v[CMD_W-1] ? -s : s;
  endfunction
endpackage

// File: rtl/plot_cmd_fifo.sv
// plot_cmd_fifo: command FIFO with push/pop/flush; flush wins over a same-cycle push or pop
module plot_cmd_fifo
  import plot_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 2 * CMD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [4:0]   count,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == 5'(DEPTH);
  assign empty = count == 5'd0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + 5'(do_push) - 5'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/plot_line_interpolator.sv
// plot_line_interpolator: APB3 queued (dx,dy) moves -> paced Bresenham step requests on two axes
// Optional PLOT_POS_COUNTER_EN adds signed position counters at 0x10/0x14.
module plot_line_interpolator
  import plot_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIR_SETUP = 4,
  parameter int PERIOD_RST = 1000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        pulse_busy,
  output logic        step_req1,
  output logic        dir1,
  output logic        step_req2,
  output logic        dir2,
  output logic        done_irq
);
  localparam logic [15:0] SETUP_LAST = 16'(DIR_SETUP > 1 ? DIR_SETUP - 1 : 0);
  state_t state, state_n;
  logic [2:0] off;
  logic wr, rd, cmd_wr, abort;
  logic [2*CMD_W-1:0] cmd;
  logic [4:0] count;
  logic full, empty;
  logic [PERIOD_W-1:0] period, timer, reload;
  logic [CMD_W:0] adx, ady, mx, mn, major, minor, remaining;
  logic signed [ERR_W-1:0] err, err_n;
  logic [15:0] setup_cnt;
  logic x_major, minor_step, in_step, last;
  logic [31:0] pos1, pos2;
  logic unused_addr;
  assign unused_addr = ^{PADDR[31:5], PADDR[1:0]};
  assign off = PADDR[4:2];
  assign wr = PSEL & PWRITE & PENABLE;
  assign rd = PSEL & ~PWRITE;
  assign cmd_wr = wr && off == OFF_CMD;
  assign abort = wr && off == OFF_CTRL && PWDATA[0];
  assign PREADY = 1'b1;
  assign PSLVERR = cmd_wr & full;
  plot_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(PCLK), .rst(PRESET), .push(cmd_wr), .pop(state == LOAD), .flush(abort),
    .din(PWDATA), .dout(cmd), .count(count), .full(full), .empty(empty)
  );
  assign adx = abs_ext(cmd[CMD_W-1:0]);
  assign ady = abs_ext(cmd[2*CMD_W-1:CMD_W]);
  assign mx = adx >= ady ? adx : ady;
  assign mn = adx >= ady ? ady : adx;
  // two cycles of fixed overhead (STEP plus the final WAIT) are folded into the reload
  assign reload = period > 16'd2 ? period - 16'd2 : '0;
  assign err_n = err - $signed({1'b0, minor});
  assign minor_step = err_n[ERR_W-1];
  assign in_step = state == STEP;
  assign last = remaining == 17'd1;
  assign step_req1 = in_step & (x_major | minor_step);
  assign step_req2 = in_step & (~x_major | minor_step);
  assign done_irq = in_step & last & empty & ~abort;
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = empty ? IDLE : LOAD;
      LOAD: state_n = mx == '0 ? IDLE : SETUP;
      SETUP: state_n = setup_cnt >= SETUP_LAST ? WAIT : SETUP;
      WAIT: state_n = (timer == '0 && !pulse_busy) ? STEP : WAIT;
      STEP: state_n = last ? IDLE : WAIT;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      period <= PERIOD_W'(PERIOD_RST);
      dir1 <= 1'b0;
      dir2 <= 1'b0;
      x_major <= 1'b0;
      major <= '0;
      minor <= '0;
      err <= '0;
      remaining <= '0;
      timer <= '0;
      setup_cnt <= '0;
    end else begin
      if (wr && off == OFF_PERIOD) period <= PWDATA[PERIOD_W-1:0];
      if (state == LOAD) begin
        dir1 <= ~cmd[CMD_W-1];
        dir2 <= ~cmd[2*CMD_W-1];
        x_major <= adx >= ady;
        major <= mx;
        minor <= mn;
        err <= $signed({1'b0, mx} >> 1);
        remaining <= mx;
        setup_cnt <= '0;
      end
      if (state == SETUP) begin
        setup_cnt <= setup_cnt + 16'd1;
        timer <= reload;
      end
      if (state == WAIT && timer != '0) timer <= timer - 1'b1;
      if (state == STEP) begin
        err <= minor_step ? err_n + $signed({1'b0, major}) : err_n;
        remaining <= remaining - 1'b1;
        timer <= reload;
      end
    end
  end
`ifdef PLOT_POS_COUNTER_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pos1 <= '0;
      pos2 <= '0;
    end else begin
      if (step_req1) pos1 <= dir1 ? pos1 + 32'd1 : pos1 - 32'd1;
      if (step_req2) pos2 <= dir2 ? pos2 + 32'd1 : pos2 - 32'd1;
    end
  end
`else
  assign pos1 = '0;
  assign pos2 = '0;
`endif
  always_comb begin
    PRDATA = '0;
    if (rd) begin
      case (off)
        OFF_PERIOD: PRDATA = {16'd0, period};
        OFF_STATUS: PRDATA = {23'd0, count, 1'b0, state != IDLE, full, empty};
        OFF_POS1: PRDATA = pos1;
        OFF_POS2: PRDATA = pos2;
        default: PRDATA = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_plot_line_interpolator.sv
// tb_plot_line_interpolator: vector table plus scoreboard of expected step events
module tb_plot_line_interpolator;
  logic PCLK = 1'b0, PRESET = 1'b1;
  logic PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0, PRDATA;
  logic PREADY, PSLVERR, pulse_busy = 1'b0;
  logic step_req1, dir1, step_req2, dir2, done_irq;
  plot_line_interpolator dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .pulse_busy(pulse_busy), .step_req1(step_req1), .dir1(dir1), .step_req2(step_req2),
    .dir2(dir2), .done_irq(done_irq)
  );
  always #5 PCLK = ~PCLK;
  typedef struct packed {logic s1, s2, d1, d2;} step_t;
  typedef struct {int period; int dx; int dy; int n1; int n2; int ndone;} vec_t;
  step_t exp_q[$];
  int gaps[$];
  int total = 0, bad = 0;
  int n1 = 0, n2 = 0, ndone = 0, cyc = 0, stable = 0, last_t = -1;
  bit expect_none = 0;
  logic pd1 = 0, pd2 = 0, e_dummy;
  logic [31:0] rdata;
  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(negedge PCLK);
    PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1;
    #1 err = PSLVERR;
    @(negedge PCLK);
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask
  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1;
    #1 d = PRDATA;
    @(negedge PCLK);
    PSEL = 0; PENABLE = 0;
  endtask
  // reference Bresenham: one scoreboard entry per major-axis step
  task automatic push_model(input int dx, input int dy);
    int adx, ady, maj, mn, err;
    bit xm, ms;
    step_t e;
    adx = dx < 0 ? -dx : dx;
    ady = dy < 0 ? -dy : dy;
    xm = adx >= ady;
    maj = xm ? adx : ady;
    mn = xm ? ady : adx;
    err = maj / 2;
    for (int k = 0; k < maj; k++) begin
      err -= mn;
      ms = err < 0;
      if (ms) err += maj;
      e.s1 = xm | ms; e.s2 = !xm | ms; e.d1 = dx >= 0; e.d2 = dy >= 0;
      exp_q.push_back(e);
    end
  endtask
  task automatic send_cmd(input int dx, input int dy);
    push_model(dx, dy);
    apb_write(32'h0, {16'(dy), 16'(dx)}, e_dummy);
  endtask
  task automatic drain(input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge PCLK);
      i++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (5) @(negedge PCLK);
  endtask
  always @(negedge PCLK) begin
    #2;
    cyc++;
    if (dir1 !== pd1 || dir2 !== pd2) stable = 0;
    else stable++;
    pd1 = dir1;
    pd2 = dir2;
    if (done_irq) ndone++;
    if (step_req1 || step_req2) begin
      n1 += int'(step_req1);
      n2 += int'(step_req2);
      if (expect_none) check("step_after_abort", 1, 0);
      else if (exp_q.size() == 0) check("unexpected_step", {step_req1, step_req2}, 0);
      else check("step_axes_dirs", {step_req1, step_req2, dir1, dir2}, exp_q.pop_front());
      check("dir_setup_ok", stable >= 4, 1);
      if (last_t >= 0) gaps.push_back(cyc - last_t);
      last_t = cyc;
    end
  end
  initial begin
    vec_t vt[6];
    int b1, b2, bd, nd0, s1;
    vt[0] = '{10, 4, 2, 4, 2, 1};
    vt[1] = '{3, -3, 0, 3, 0, 1};
    vt[2] = '{4, 0, 0, 0, 0, 0};
    vt[3] = '{5, 2, 2, 2, 2, 1};
    vt[4] = '{2, -1, 5, 1, 5, 1};
    vt[5] = '{6, 3, -7, 3, 7, 1};
    #2;
    check("rst_outs", {step_req1, step_req2, dir1, dir2, done_irq, PSLVERR}, 0);
    check("pready", PREADY, 1);
    repeat (3) @(negedge PCLK);
    PRESET = 0;
    apb_read(32'h4, rdata);
    check("rst_period", rdata, 1000);
    apb_read(32'h8, rdata);
    check("rst_status", rdata, 1);
    apb_read(32'h1C, rdata);
    check("unmapped_read", rdata, 0);
    for (int v = 0; v < 6; v++) begin
      b1 = n1; b2 = n2; bd = ndone;
      apb_write(32'h4, vt[v].period, e_dummy);
      last_t = -1;
      gaps.delete();
      send_cmd(vt[v].dx, vt[v].dy);
      drain(2000);
      check("vec_n1", n1 - b1, vt[v].n1);
      check("vec_n2", n2 - b2, vt[v].n2);
      check("vec_done", ndone - bd, vt[v].ndone);
      foreach (gaps[g]) check("vec_gap", gaps[g], vt[v].period);
      apb_read(32'h8, rdata);
      check("vec_status", rdata, 1);
    end
    // FIFO full while the interpolator is stalled by pulse_busy
    apb_write(32'h4, 2, e_dummy);
    pulse_busy = 1;
    bd = ndone;
    send_cmd(1, 0);
    repeat (10) @(negedge PCLK);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) push_model(1, 0);
      apb_write(32'h0, {16'd0, 16'd1}, e_dummy);
      check("full_pslverr", e_dummy, i == 4 ? 1 : 0);
    end
    apb_read(32'h8, rdata);
    check("full_status", rdata, 32'h46);
    s1 = n1;
    repeat (50) @(negedge PCLK);
    check("busy_stall", n1 - s1, 0);
    pulse_busy = 0;
    drain(500);
    check("full_n1", n1 - s1, 5);
    check("full_done", ndone - bd, 1);
    // abort mid-move with a second move still queued
    apb_write(32'h4, 10, e_dummy);
    send_cmd(100, 0);
    send_cmd(100, 0);
    repeat (60) @(negedge PCLK);
    nd0 = ndone;
    apb_write(32'hC, 1, e_dummy);
    exp_q.delete();
    expect_none = 1;
    repeat (200) @(negedge PCLK);
    apb_read(32'h8, rdata);
    check("abort_status", rdata, 1);
    check("abort_done", ndone - nd0, 0);
    check("abort_dir_held", dir1, 1);
    expect_none = 0;
    // reset mid-move
    apb_write(32'h4, 7, e_dummy);
    send_cmd(50, 30);
    repeat (40) @(negedge PCLK);
    PRESET = 1;
    exp_q.delete();
    #2;
    check("rst_mid_outs", {step_req1, step_req2, dir1, dir2, done_irq, PSLVERR}, 0);
    repeat (3) @(negedge PCLK);
    PRESET = 0;
    apb_read(32'h4, rdata);
    check("rst_mid_period", rdata, 1000);
    apb_read(32'h8, rdata);
    check("rst_mid_status", rdata, 1);
    // position counters
    apb_write(32'h4, 2, e_dummy);
    send_cmd(5, 0);
    drain(500);
    send_cmd(-2, 0);
    drain(500);
    apb_read(32'h10, rdata);
`ifdef PLOT_POS_COUNTER_EN
    check("pos1", rdata, 3);
`else
    check("pos1", rdata, 0);
`endif
    apb_read(32'h14, rdata);
    check("pos2", rdata, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
